// File: rtl/corepwm_timebase_if.sv
// Register-side bundle between the APB register block and the PWM timebase.
// The master drives the programmed values; the slave (timebase) drives the tick/count outputs.
interface corepwm_timebase_if #(
    parameter int PWM_NUM    = 8,
    parameter int APB_DWIDTH = 8
);
    logic [APB_DWIDTH-1:0]       prescale_reg;
    logic [APB_DWIDTH-1:0]       period_reg;
    logic [PWM_NUM*APB_DWIDTH:1] posedge_in;
    logic [PWM_NUM*APB_DWIDTH:1] negedge_in;
    logic                        sync_update;

    logic [APB_DWIDTH-1:0]       period_cnt;
    logic                        sync_pulse;
    logic                        period_end;
    logic [PWM_NUM*APB_DWIDTH:1] pwm_posedge_reg;
    logic [PWM_NUM*APB_DWIDTH:1] pwm_negedge_reg;

    modport master (
        output prescale_reg,
        output period_reg,
        output posedge_in,
        output negedge_in,
        output sync_update,
        input  period_cnt,
        input  sync_pulse,
        input  period_end,
        input  pwm_posedge_reg,
        input  pwm_negedge_reg
    );

    modport slave (
        input  prescale_reg,
        input  period_reg,
        input  posedge_in,
        input  negedge_in,
        input  sync_update,
        output period_cnt,
        output sync_pulse,
        output period_end,
        output pwm_posedge_reg,
        output pwm_negedge_reg
    );
endinterface

// File: rtl/corepwm_timebase.sv
// PWM timebase: prescaled sync tick, shared wrapping period counter and edge-register staging.
// Define COREPWM_SHADOW_REG_EN to double-buffer the edge registers up to a period boundary.
module corepwm_timebase #(
    parameter int PWM_NUM    = 8,
    parameter int APB_DWIDTH = 8
) (
    input  logic                PCLK,
    input  logic                PRESETN,
    corepwm_timebase_if.slave   bus
);
    localparam int EW = PWM_NUM * APB_DWIDTH;
    localparam logic [APB_DWIDTH-1:0] ONE = {{(APB_DWIDTH-1){1'b0}}, 1'b1};

    logic [APB_DWIDTH-1:0] prescale_cnt_q;
    logic [APB_DWIDTH-1:0] prescale_cnt_d;
    logic                  sync_pulse_q;
    logic                  sync_pulse_d;
    logic [APB_DWIDTH-1:0] period_cnt_q;
    logic [APB_DWIDTH-1:0] period_cnt_d;
    logic                  prescale_wrap;
    logic                  period_wrap;
    logic                  period_end;

    // >= rather than == so a live reduction of either limit wraps at once instead of overrunning.
    always_comb begin
        prescale_wrap  = (prescale_cnt_q >= bus.prescale_reg);
        period_wrap    = (period_cnt_q >= bus.period_reg);
        prescale_cnt_d = prescale_wrap ? '0 : (prescale_cnt_q + ONE);
        sync_pulse_d   = prescale_wrap;
        period_cnt_d   = period_cnt_q;
        if (sync_pulse_q) begin
            period_cnt_d = period_wrap ? '0 : (period_cnt_q + ONE);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            prescale_cnt_q <= '0;
            sync_pulse_q   <= 1'b0;
            period_cnt_q   <= '0;
        end else begin
            prescale_cnt_q <= prescale_cnt_d;
            sync_pulse_q   <= sync_pulse_d;
            period_cnt_q   <= period_cnt_d;
        end
    end

    assign period_end     = sync_pulse_q & period_wrap;
    assign bus.period_end = period_end;
    assign bus.sync_pulse = sync_pulse_q;
    assign bus.period_cnt = period_cnt_q;

`ifdef COREPWM_SHADOW_REG_EN
    logic          shadow_load;
    logic [EW:1]   pos_all;
    logic [EW:1]   neg_all;
    genvar         gi;

    // Transfer happens on the edge closing the period_end tick, so new edges start at count 0.
    assign shadow_load = period_end & bus.sync_update;

    for (gi = 1; gi <= PWM_NUM; gi++) begin : g_ch
        logic [APB_DWIDTH-1:0] pos_q;
        logic [APB_DWIDTH-1:0] pos_d;
        logic [APB_DWIDTH-1:0] neg_q;
        logic [APB_DWIDTH-1:0] neg_d;

        always_comb begin
            pos_d = pos_q;
            neg_d = neg_q;
            if (shadow_load) begin
                pos_d = bus.posedge_in[gi*APB_DWIDTH -: APB_DWIDTH];
                neg_d = bus.negedge_in[gi*APB_DWIDTH -: APB_DWIDTH];
            end
        end

        always_ff @(posedge PCLK or negedge PRESETN) begin
            if (!PRESETN) begin
                pos_q <= '0;
                neg_q <= '0;
            end else begin
                pos_q <= pos_d;
                neg_q <= neg_d;
            end
        end

        assign pos_all[gi*APB_DWIDTH -: APB_DWIDTH] = pos_q;
        assign neg_all[gi*APB_DWIDTH -: APB_DWIDTH] = neg_q;
    end

    assign bus.pwm_posedge_reg = pos_all;
    assign bus.pwm_negedge_reg = neg_all;
`else
    logic unused_sync_update;

    assign unused_sync_update  = bus.sync_update;
    assign bus.pwm_posedge_reg = bus.posedge_in;
    assign bus.pwm_negedge_reg = bus.negedge_in;
`endif
endmodule

// File: tb/tb_corepwm_timebase.sv
// Directed bench for corepwm_timebase: tick/counter sequences, live period change, reset, edge staging.
module tb_corepwm_timebase;
    localparam int NCH = 8;
    localparam int DW  = 8;

    logic PCLK;
    logic PRESETN;
    int   chk_cnt;
    int   pass_cnt;

    corepwm_timebase_if #(.PWM_NUM(NCH), .APB_DWIDTH(DW)) bus ();

    corepwm_timebase #(.PWM_NUM(NCH), .APB_DWIDTH(DW)) dut (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .bus     (bus.slave)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Expected per-cycle outputs after release with prescale_reg=0, period_reg=3
    int s1_sync[9] = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
    int s1_cnt[9]  = '{0, 0, 1, 2, 3, 0, 1, 2, 3};
    int s1_end[9]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
    // prescale_reg=2, period_reg=1
    int s2_sync[13] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    int s2_cnt[13]  = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};
    int s2_end[13]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cycle(input string tag, input int k, input int es, input int ec, input int ee);
        chk($sformatf("%s_sync_c%0d", tag, k), {31'd0, bus.sync_pulse}, es[31:0]);
        chk($sformatf("%s_cnt_c%0d", tag, k), {24'd0, bus.period_cnt}, ec[31:0]);
        chk($sformatf("%s_end_c%0d", tag, k), {31'd0, bus.period_end}, ee[31:0]);
        $display("%s cycle %0d: sync=%0d cnt=%0d end=%0d", tag, k, bus.sync_pulse, bus.period_cnt, bus.period_end);
    endtask

    task automatic release_rst();
        @(negedge PCLK);
        PRESETN = 1'b1;
        #1;
    endtask

    task automatic run_seq1(input string tag);
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge PCLK);
            chk_cycle(tag, k, s1_sync[k], s1_cnt[k], s1_end[k]);
        end
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        PRESETN  = 1'b0;
        bus.prescale_reg = 8'd0;
        bus.period_reg   = 8'd3;
        bus.posedge_in   = '0;
        bus.negedge_in   = '0;
        bus.sync_update  = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("rst_sync", {31'd0, bus.sync_pulse}, 32'd0);
        chk("rst_cnt", {24'd0, bus.period_cnt}, 32'd0);
        chk("rst_end", {31'd0, bus.period_end}, 32'd0);

        // Scenario 1: continuous ticks, period of 4
        release_rst();
        run_seq1("s1");

`ifdef COREPWM_SHADOW_REG_EN
        // Now at cycle 8 (cnt=3, period_end). Stage channel 1 with sync_update low.
        bus.posedge_in[8:1]  = 8'h20;
        bus.negedge_in[16:9] = 8'h33;
        bus.sync_update      = 1'b0;
        repeat (9) @(negedge PCLK);
        chk("shd_hold_pos", {24'd0, bus.pwm_posedge_reg[8:1]}, 32'h00);
        chk("shd_hold_neg", {24'd0, bus.pwm_negedge_reg[16:9]}, 32'h00);
        $display("shadow hold: pos_ch1=0x%0h", bus.pwm_posedge_reg[8:1]);
        bus.sync_update = 1'b1;
        begin
            int waited;
            waited = 0;
            @(negedge PCLK);
            while (!bus.period_end && waited < 20) begin
                @(negedge PCLK);
                waited++;
            end
            chk("shd_wait_pend", {31'd0, bus.period_end}, 32'd1);
        end
        chk("shd_pre_pos", {24'd0, bus.pwm_posedge_reg[8:1]}, 32'h00);
        @(negedge PCLK);
        chk("shd_load_pos", {24'd0, bus.pwm_posedge_reg[8:1]}, 32'h20);
        chk("shd_load_neg", {24'd0, bus.pwm_negedge_reg[16:9]}, 32'h33);
        chk("shd_load_cnt", {24'd0, bus.period_cnt}, 32'd0);
        $display("shadow load: pos_ch1=0x%0h cnt=%0d", bus.pwm_posedge_reg[8:1], bus.period_cnt);
        // sync_update withdrawn before the next period_end: no transfer
        bus.posedge_in[8:1] = 8'h55;
        @(negedge PCLK);
        bus.sync_update = 1'b0;
        repeat (4) @(negedge PCLK);
        chk("shd_drop_pos", {24'd0, bus.pwm_posedge_reg[8:1]}, 32'h20);
        // Raise sync_update in the period_end cycle itself
        repeat (2) @(negedge PCLK);
        chk("shd_coin_pend", {31'd0, bus.period_end}, 32'd1);
        bus.sync_update = 1'b1;
        @(negedge PCLK);
        chk("shd_coin_pos", {24'd0, bus.pwm_posedge_reg[8:1]}, 32'h55);
        $display("shadow coincident: pos_ch1=0x%0h", bus.pwm_posedge_reg[8:1]);
        bus.sync_update = 1'b0;
`else
        bus.sync_update = 1'b0;
        bus.negedge_in  = 64'hA5C3_0F1E_7788_1234;
        #1;
        chk("pass_neg_su0", bus.pwm_negedge_reg[32:1], 32'h7788_1234);
        chk("pass_neg_hi", bus.pwm_negedge_reg[64:33], 32'hA5C3_0F1E);
        bus.sync_update = 1'b1;
        bus.negedge_in  = 64'h0102_0304_0506_0708;
        bus.posedge_in  = 64'h0000_0000_0000_2000;
        #1;
        chk("pass_neg_su1", bus.pwm_negedge_reg[32:1], 32'h0506_0708);
        chk("pass_pos_su1", {24'd0, bus.pwm_posedge_reg[16:9]}, 32'h20);
        $display("passthrough: neg=0x%0h", bus.pwm_negedge_reg);
        bus.sync_update = 1'b0;
`endif

        // Scenario 2: prescale 3, period 2 ticks -> 6 PCLK period
        PRESETN = 1'b0;
        bus.prescale_reg = 8'd2;
        bus.period_reg   = 8'd1;
        @(negedge PCLK);
        release_rst();
        for (int k = 0; k < 13; k++) begin
            if (k > 0) @(negedge PCLK);
            chk_cycle("s2", k, s2_sync[k], s2_cnt[k], s2_end[k]);
        end

        // Scenario 6: reset asserted mid-period at cnt=2, prescale_cnt=1 (cycle 7)
        PRESETN = 1'b0;
        bus.period_reg = 8'd3;
        @(negedge PCLK);
        release_rst();
        repeat (7) @(negedge PCLK);
        chk("mid_cnt_pre", {24'd0, bus.period_cnt}, 32'd2);
        #2;
        PRESETN = 1'b0;
        #1;
        chk("mid_cnt_rst", {24'd0, bus.period_cnt}, 32'd0);
        chk("mid_sync_rst", {31'd0, bus.sync_pulse}, 32'd0);
        chk("mid_end_rst", {31'd0, bus.period_end}, 32'd0);
`ifdef COREPWM_SHADOW_REG_EN
        chk("mid_pos_rst", {24'd0, bus.pwm_posedge_reg[8:1]}, 32'h00);
        chk("mid_neg_rst", {24'd0, bus.pwm_negedge_reg[16:9]}, 32'h00);
`endif
        $display("async reset: cnt=%0d sync=%0d", bus.period_cnt, bus.sync_pulse);
        bus.prescale_reg = 8'd0;
        bus.period_reg   = 8'd3;
        release_rst();
        run_seq1("s6");

        // Scenario 3: lower period_reg from 200 to 10 while cnt=150 (prescale 2)
        PRESETN = 1'b0;
        bus.prescale_reg = 8'd1;
        bus.period_reg   = 8'd200;
        @(negedge PCLK);
        release_rst();
        repeat (301) @(negedge PCLK);
        chk_cycle("s3", 301, 0, 150, 0);
        bus.period_reg = 8'd10;
        @(negedge PCLK);
        chk_cycle("s3", 302, 1, 150, 1);
        @(negedge PCLK);
        chk_cycle("s3", 303, 0, 0, 0);
        @(negedge PCLK);
        chk_cycle("s3", 304, 1, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/corepwm_timebase.md
# corepwm_timebase

Timebase and register-staging stage that sits directly upstream of the PWM output generator. Divides PCLK by a programmable prescale to produce the one-cycle `sync_pulse` tick, and runs the shared period counter `period_cnt`, which wraps at a programmable period. Optionally double-buffers the per-channel edge registers so that new duty values take effect only at a period boundary. All outputs go straight to the PWM generator.

## Interface
- `PWM_NUM`, default 8: number of PWM channels.
- `APB_DWIDTH`, default 8: width of counters and edge registers.

Ports:
- `PCLK`  in  1  system clock.
- `PRESETN`  in  1  asynchronous, active-low reset.
- `prescale_reg`  in  APB_DWIDTH  tick divisor minus 1.
- `period_reg`  in  APB_DWIDTH  terminal count of `period_cnt`.
- `posedge_in`  in  PWM_NUM*APB_DWIDTH [PWM_NUM*APB_DWIDTH:1]  APB-written rising-edge values; channel z occupies [z*APB_DWIDTH:(z-1)*APB_DWIDTH+1].
- `negedge_in`  in  PWM_NUM*APB_DWIDTH  APB-written falling-edge values; same packing.
- `sync_update`  in  1  level; 1 = transfer staged edges at next period end.
- `period_cnt`  out  APB_DWIDTH  shared period counter.
- `sync_pulse`  out  1  one-PCLK tick.
- `period_end`  out  1  tick on which `period_cnt` wraps.
- `pwm_posedge_reg`  out  PWM_NUM*APB_DWIDTH  active rising-edge values.
- `pwm_negedge_reg`  out  PWM_NUM*APB_DWIDTH  active falling-edge values.

## Operation
- Reset values: `prescale_cnt`=0, `period_cnt`=0, `sync_pulse`=0, and `period_end`=0. Shadowed `pwm_posedge_reg`/`pwm_negedge_reg` reset to 0.
- Prescaler:
  - Per edge, if `prescale_cnt` >= `prescale_reg`, then `prescale_cnt`<=0 and `sync_pulse`<=1.
  - Otherwise `prescale_cnt`<=`prescale_cnt`+1 and `sync_pulse`<=0.
  - `sync_pulse` is a registered output.
  - The compare is >= so that lowering `prescale_reg` below the current count wraps on the next edge and never runs to 2^APB_DWIDTH.
- Period counter:
  - Advances only on an edge where `sync_pulse`=1.
  - If `period_cnt` >= `period_reg`, it goes to 0; otherwise it increments by 1.
  - All arithmetic is unsigned, APB_DWIDTH bits, with no carry out.
  - `period_reg`=0 holds `period_cnt` at 0, and every tick is a period end.
- `period_end` = `sync_pulse` AND (`period_cnt` >= `period_reg`). It is decoded only from registers, so it is stable for the whole cycle.
- `period_cnt` is held constant for the entire cycle in which `sync_pulse`=1. The downstream generator compares on that cycle.
- `prescale_reg` and `period_reg` are used live. A change is seen on the next edge.

## Timing
- `sync_pulse` rate is PCLK/(`prescale_reg`+1).
  - `prescale_reg`=0 gives `sync_pulse` continuously 1 from the first edge after reset release.
- `period_cnt` updates on the PCLK edge that ends a `sync_pulse`=1 cycle. Its latency from tick to new count is 1 edge.
- After reset release with `prescale_reg`=0, `period_cnt` is 0 for cycles 0 and 1, then 1, 2, … from cycle 2.
- Full period length in PCLK cycles is (`prescale_reg`+1)*(`period_reg`+1).
- Asserting PRESETN low mid-period clears all state immediately. It does not wait for a period boundary. Counting restarts from 0 on release.
- Staged edge transfer (macro on):
  - Occurs on the edge ending a `period_end` cycle, if `sync_update`=1 in that cycle.
  - New values are therefore visible from the first tick of the next period (`period_cnt`=0).
- If `sync_update` and `period_end` go high in the same cycle, the transfer happens on that edge.
- If `sync_update` falls before `period_end`, no transfer occurs.

## Configuration
- Macro `COREPWM_SHADOW_REG_EN`.
- When defined:
  - `pwm_posedge_reg`/`pwm_negedge_reg` are registers, PWM_NUM*APB_DWIDTH bits each.
  - They load from `posedge_in`/`negedge_in` only as described under Timing.
  - Outside those edges they hold their value.
- When undefined:
  - Each output is a direct continuous assignment from the matching input.
  - `sync_update` is ignored.
  - No edge registers exist.
  - Timebase behaviour is identical in both cases.

## Test plan
- Reset, `prescale_reg`=0, `period_reg`=3 -> `sync_pulse`=1 every cycle from cycle 1; `period_cnt` 0,0,1,2,3,0,1…; `period_end`=1 exactly when `period_cnt`=3.
- `prescale_reg`=2, `period_reg`=1 -> `sync_pulse` high 1 cycle in 3; `period_cnt` toggles 0/1 once per tick; period is 6 PCLK cycles.
- Running with `period_reg`=200, `period_cnt`=150, write `period_reg`=10 -> next tick `period_cnt`=0 with `period_end`=1; no count beyond 150.
- Macro on, channel 1 `posedge_in`=0x20, `sync_update`=0 for 2 periods -> `pwm_posedge_reg` stays 0x00. Then set `sync_update`=1 -> changes to 0x20 on the edge after the next `period_end`, while `period_cnt` goes to 0.
- Macro off -> `pwm_negedge_reg` follows `negedge_in` in the same cycle regardless of `sync_update`.
- PRESETN pulsed low at `period_cnt`=2, `prescale_cnt`=1 -> all outputs 0 asynchronously; after release, the sequence matches the first scenario.
